fp_mul_seq_core: RTL and testbench

FP_MUL_SEQ_CORE -- requirements
Module: fp_mul_seq_core

---
 rtl/fp_mul_pkg.sv | 20 ++
 rtl/fp_mul_round.sv | 55 +++++
 rtl/fp_mul_seq_core.sv | 122 ++++++++++++
 tb/tb_fp_mul_seq_core.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/fp_mul_pkg.sv
// Shared types and constants for the sequential single-precision multiplier core.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fp_mul_pkg;

   localparam int MANT_W  = 24;
   localparam int PROD_W  = 48;
   localparam int EXP_W   = 10;
   localparam int BIAS    = 127;
   localparam int EXP_MAX = 255;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_MUL,
      ST_NORM,
      ST_ROUND,
      ST_DONE
   } state_t;

endpackage

// File: rtl/fp_mul_round.sv
// Rounds a normalized fraction and packs sign/exponent/fraction into IEEE-754 single,
// latency: purely combinational; FP_MUL_RNE_EN selects round-to-nearest-even, else truncation.
// Backpressure: none, the caller registers the packed word.
module fp_mul_round
   import fp_mul_pkg::*;
(
   input  logic                    [22:0] frac_in,
   input  logic                           guard,
   input  logic                           sticky,
   input  logic signed [EXP_W-1:0]        exp_in,
   input  logic                           sign,
   input  logic                           zero,
   output logic                    [31:0] result
);

   logic                    inc;
   logic             [23:0] sum;
   logic             [22:0] frac;
   logic signed [EXP_W-1:0] e_adj;

`ifdef FP_MUL_RNE_EN
   // Round half to even: bump on guard unless exactly halfway with an even lsb.
   always_comb begin
      inc = guard & (sticky | frac_in[0]);
   end
`else
   // Truncation: guard and sticky play no part in the result.
   logic unused_round_bits;
   always_comb begin
      unused_round_bits = guard ^ sticky;
      inc               = 1'b0;
   end
`endif

   // Apply the increment, fold a fraction carry-out into the exponent, then classify.
   always_comb begin
      sum   = {1'b0, frac_in} + {23'd0, inc};
      frac  = sum[22:0];
      e_adj = exp_in;
      if (sum[23]) begin
         frac  = 23'd0;
         e_adj = exp_in + 10'sd1;
      end

      result = {sign, e_adj[7:0], frac};
      if (zero) begin
         result = {sign, 31'd0};
      end else if (int'(e_adj) >= EXP_MAX) begin
         result = {sign, 8'hFF, 23'd0};
      end else if (int'(e_adj) <= 0) begin
         result = {sign, 31'd0};
      end
   end

endmodule

// File: rtl/fp_mul_seq_core.sv
// Sequential FP32 significand multiplier (radix-2 shift-add) with normalize/round/pack; build option FP_MUL_RNE_EN.
// Latency: result valid 26 edges after accept (24 MUL + NORM + ROUND), one operation in flight.
// Backpressure: in_ready only in IDLE; result and out_valid held in DONE until out_ready.
module fp_mul_seq_core
   import fp_mul_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [23:0] mul1_mantissa_normalized,
   input  logic [23:0] mul2_mantissa_normalized,
   input  logic [4:0]  mul1_shift,
   input  logic [4:0]  mul2_shift,
   input  logic [7:0]  current_exponent,
   input  logic        result_sign,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] result
);

   state_t                  state_q, state_d;
   logic             [4:0]  cnt_q;
   logic      [PROD_W-1:0]  acc_q;
   logic      [MANT_W-1:0]  a_q, b_q;
   logic signed [EXP_W-1:0] exp_q;
   logic                    sign_q, zero_q;
   logic             [22:0] frac_q;
   logic                    guard_q, sticky_q;
   logic             [31:0] result_q;
   logic             [31:0] packed_res;

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic and handshake outputs.
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_d = ST_MUL;
         end
         ST_MUL:   if (cnt_q == 5'd23) state_d = ST_NORM;
         ST_NORM:  state_d = ST_ROUND;
         ST_ROUND: state_d = ST_DONE;
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = ST_IDLE;
         end
         default:  state_d = ST_IDLE;
      endcase
   end

   // Operand capture, shift-add iteration, normalization and result register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q    <= 5'd0;
         acc_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         exp_q    <= '0;
         sign_q   <= 1'b0;
         zero_q   <= 1'b0;
         frac_q   <= '0;
         guard_q  <= 1'b0;
         sticky_q <= 1'b0;
         result_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: if (in_valid) begin
               a_q    <= mul1_mantissa_normalized;
               b_q    <= mul2_mantissa_normalized;
               // Shift compensation now; the p[47] term is added once normalization is known.
               exp_q  <= $signed({2'b00, current_exponent})
                       - $signed({5'd0, mul1_shift})
                       - $signed({5'd0, mul2_shift});
               sign_q <= result_sign;
               zero_q <= (mul1_mantissa_normalized == '0) || (mul2_mantissa_normalized == '0);
               cnt_q  <= 5'd0;
               acc_q  <= '0;
            end
            ST_MUL: begin
               if (b_q[cnt_q]) acc_q <= acc_q + ({24'd0, a_q} << cnt_q);
               cnt_q <= (cnt_q == 5'd23) ? 5'd0 : cnt_q + 5'd1;
            end
            ST_NORM: begin
               if (acc_q[47]) begin
                  frac_q   <= acc_q[46:24];
                  guard_q  <= acc_q[23];
                  sticky_q <= |acc_q[22:0];
                  exp_q    <= exp_q + 10'sd1;
               end else begin
                  frac_q   <= acc_q[45:23];
                  guard_q  <= acc_q[22];
                  sticky_q <= |acc_q[21:0];
               end
            end
            ST_ROUND: result_q <= packed_res;
            default: ;
         endcase
      end
   end

   fp_mul_round u_round (
      .frac_in (frac_q),
      .guard   (guard_q),
      .sticky  (sticky_q),
      .exp_in  (exp_q),
      .sign    (sign_q),
      .zero    (zero_q),
      .result  (packed_res)
   );

   assign result = result_q;

endmodule

// File: tb/tb_fp_mul_seq_core.sv
// Directed table-driven bench for fp_mul_seq_core plus backpressure and mid-operation reset sequences.
// Latency: expects out_valid exactly 26 edges after the accepting edge.
// Backpressure: exercises out_ready held low in DONE and in_valid asserted while busy.
module tb_fp_mul_seq_core;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [23:0] mul1_mantissa_normalized;
   logic [23:0] mul2_mantissa_normalized;
   logic [4:0]  mul1_shift;
   logic [4:0]  mul2_shift;
   logic [7:0]  current_exponent;
   logic        result_sign;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [23:0] a;
      logic [23:0] b;
      logic [4:0]  s1;
      logic [4:0]  s2;
      logic [7:0]  e;
      logic        sign;
      logic [31:0] exp_rne;
      logic [31:0] exp_trn;
   } vec_t;

   vec_t vecs[13];

   fp_mul_seq_core dut (
      .clk                      (clk),
      .rst_n                    (rst_n),
      .in_valid                 (in_valid),
      .in_ready                 (in_ready),
      .mul1_mantissa_normalized (mul1_mantissa_normalized),
      .mul2_mantissa_normalized (mul2_mantissa_normalized),
      .mul1_shift               (mul1_shift),
      .mul2_shift               (mul2_shift),
      .current_exponent         (current_exponent),
      .result_sign              (result_sign),
      .out_valid                (out_valid),
      .out_ready                (out_ready),
      .result                   (result)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] pick(input vec_t v);
`ifdef FP_MUL_RNE_EN
      return v.exp_rne;
`else
      return v.exp_trn;
`endif
   endfunction

   task automatic start_op(input vec_t v);
      int w = 0;
      while (!in_ready && w < 50) begin
         @(posedge clk); #1; w++;
      end
      chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
      mul1_mantissa_normalized = v.a;
      mul2_mantissa_normalized = v.b;
      mul1_shift               = v.s1;
      mul2_shift               = v.s2;
      current_exponent         = v.e;
      result_sign              = v.sign;
      in_valid                 = 1'b1;
      @(posedge clk); #1;
      in_valid                 = 1'b0;
      // Scramble inputs after accept: only the registered copies may matter.
      mul1_mantissa_normalized = 24'h5A5A5A;
      mul2_mantissa_normalized = 24'hA5A5A5;
      mul1_shift               = 5'd7;
      mul2_shift               = 5'd3;
      current_exponent         = 8'h11;
      result_sign              = ~v.sign;
   endtask

   task automatic wait_done(output logic [31:0] res, output int lat);
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(posedge clk); #1; lat++;
      end
      res = result;
   endtask

   task automatic retire();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   initial begin
      logic [31:0] res;
      int          lat;
      int          spurious;
      logic        stable;

      //           a          b          s1  s2  e     sg  rne           trunc
      vecs[0]  = '{24'hC00000, 24'h800000, 0,  0,  128, 0, 32'h40400000, 32'h40400000};
      vecs[1]  = '{24'hC00000, 24'hC00000, 0,  0,  254, 0, 32'h7F800000, 32'h7F800000};
      vecs[2]  = '{24'hC00000, 24'hC00000, 1,  0,  0,   1, 32'h80000000, 32'h80000000};
      vecs[3]  = '{24'hC00000, 24'hC00000, 0,  0,  0,   1, 32'h80900000, 32'h80900000};
      vecs[4]  = '{24'h800001, 24'hC00000, 0,  0,  127, 0, 32'h3FC00002, 32'h3FC00001};
      vecs[5]  = '{24'h000000, 24'hC00000, 0,  0,  140, 1, 32'h80000000, 32'h80000000};
      vecs[6]  = '{24'hFFFFFE, 24'h800001, 0,  0,  127, 0, 32'h40000000, 32'h3FFFFFFF};
      vecs[7]  = '{24'h800003, 24'hC00000, 0,  0,  127, 1, 32'hBFC00004, 32'hBFC00004};
      vecs[8]  = '{24'hC00000, 24'h800000, 1,  2,  130, 0, 32'h3FC00000, 32'h3FC00000};
      vecs[9]  = '{24'hC00000, 24'h800000, 31, 31, 5,   1, 32'h80000000, 32'h80000000};
      vecs[10] = '{24'h800000, 24'h800000, 0,  0,  254, 0, 32'h7F000000, 32'h7F000000};
      vecs[11] = '{24'hC00000, 24'h000000, 0,  0,  254, 0, 32'h00000000, 32'h00000000};
      vecs[12] = '{24'hFFFFFE, 24'h800001, 0,  0,  254, 0, 32'h7F800000, 32'h7F7FFFFF};

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      mul1_mantissa_normalized = '0; mul2_mantissa_normalized = '0;
      mul1_shift = '0; mul2_shift = '0; current_exponent = '0; result_sign = 1'b0;

      // Reset state, held while rst_n is low.
      repeat (2) @(posedge clk);
      #1;
      chk("reset_in_ready",  {31'd0, in_ready},  32'd1);
      chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
      chk("reset_result",    result,             32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Table of directed vectors.
      for (int i = 0; i < 13; i++) begin
         start_op(vecs[i]);
         chk($sformatf("busy_in_ready_%0d", i), {31'd0, in_ready}, 32'd0);
         wait_done(res, lat);
         chk($sformatf("latency_%0d", i), lat, 32'd26);
         chk($sformatf("result_%0d", i), res, pick(vecs[i]));
         retire();
         chk($sformatf("retire_out_valid_%0d", i), {31'd0, out_valid}, 32'd0);
         chk($sformatf("retire_in_ready_%0d", i),  {31'd0, in_ready},  32'd1);
      end

      // Backpressure: out_ready low for 5 DONE cycles, in_valid asserted meanwhile.
      start_op(vecs[4]);
      wait_done(res, lat);
      chk("bp_latency", lat, 32'd26);
      stable = 1'b1;
      in_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         if (result !== pick(vecs[4]) || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
         @(posedge clk); #1;
      end
      chk("bp_stable_5_cycles", {31'd0, stable}, 32'd1);
      chk("bp_result_6th", result, pick(vecs[4]));
      in_valid = 1'b0;
      retire();
      chk("bp_in_ready_after", {31'd0, in_ready},  32'd1);
      chk("bp_out_valid_after", {31'd0, out_valid}, 32'd0);

      // Reset mid-MUL: accept, advance counter to 10, reset for one edge.
      start_op(vecs[0]);
      repeat (10) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("mid_rst_in_ready",  {31'd0, in_ready},  32'd1);
      chk("mid_rst_result",    result,             32'd0);
      spurious = 0;
      for (int k = 0; k < 30; k++) begin
         if (out_valid) spurious++;
         @(posedge clk); #1;
      end
      chk("mid_rst_no_output", spurious, 32'd0);

      // Fresh operation after the aborted one.
      start_op(vecs[7]);
      wait_done(res, lat);
      chk("post_rst_latency", lat, 32'd26);
      chk("post_rst_result", res, pick(vecs[7]));
      retire();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
